// File: rtl/eth_cfg_seq.sv
// eth_cfg_seq: command FIFO and pacing sequencer in front of the usr_* config port.
// Optional write readback check: define ETH_CFG_SEQ_WR_VERIFY_EN.
module eth_cfg_seq #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int WR_GAP     = 16,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          seq_en,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rd,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [DATA_WIDTH-1:0]         cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          eth_en,
    input  logic                          eth_rst_done,
    input  logic                          eth_init_done,
    output logic                          usr_wr_en,
    output logic [ADDR_WIDTH-1:0]         usr_wr_addr,
    output logic [DATA_WIDTH-1:0]         usr_wr_data,
    output logic                          usr_rd_en,
    output logic [ADDR_WIDTH-1:0]         usr_rd_addr,
    input  logic                          usr_rd_vld,
    input  logic [DATA_WIDTH-1:0]         usr_rd_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   err_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int GW = $clog2(WR_GAP + 1);
    localparam int TW = $clog2(RD_TIMEOUT);

    typedef enum logic [2:0] {
        S_DISABLED,
        S_WAIT_INIT,
        S_IDLE,
        S_WR,
        S_GAP,
        S_RD,
        S_RD_WAIT,
        S_RSP
    } state_t;

    state_t state_q, state_d;

    logic [FW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic                  head_rd;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [GW-1:0]         gap_cnt;
    logic [TW-1:0]         tmr;
    logic                  gap_last, tmr_last;

    logic                  rsp_ld, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  eth_en_q;
    logic [15:0]           err_cnt_q;

`ifdef ETH_CFG_SEQ_WR_VERIFY_EN
    logic                  vfy_q, vfy_start;
`endif

    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign cmd_ready  = !fifo_full && seq_en && !rst;
    assign push       = cmd_valid && cmd_ready;
    assign {head_rd, head_addr, head_data} = mem[rd_ptr];

    assign gap_last = (gap_cnt == GW'(WR_GAP - 1));
    assign tmr_last = (tmr == TW'(RD_TIMEOUT - 1));

    // Command storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_rd, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy; dropping seq_en flushes the queue.
    always_ff @(posedge clk) begin
        if (rst || !seq_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, FIFO pop and response load decisions.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        rsp_ld     = 1'b0;
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
`ifdef ETH_CFG_SEQ_WR_VERIFY_EN
        vfy_start  = 1'b0;
`endif
        if (!seq_en) begin
            state_d = S_DISABLED;
        end else begin
            unique case (state_q)
                S_DISABLED: state_d = S_WAIT_INIT;
                S_WAIT_INIT: begin
                    if (eth_rst_done && eth_init_done) state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (!eth_init_done) begin
                        state_d = S_WAIT_INIT;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = head_rd ? S_RD : S_WR;
                    end
                end
                S_WR: state_d = eth_init_done ? S_GAP : S_WAIT_INIT;
                S_GAP: begin
                    if (!eth_init_done) begin
                        state_d = S_WAIT_INIT;
                    end else if (gap_last) begin
`ifdef ETH_CFG_SEQ_WR_VERIFY_EN
                        state_d   = S_RD;
                        vfy_start = 1'b1;
`else
                        state_d   = S_IDLE;
`endif
                    end
                end
                S_RD: begin
                    if (!eth_init_done) begin
                        state_d   = S_RSP;
                        rsp_ld    = 1'b1;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (!eth_init_done) begin
                        state_d   = S_RSP;
                        rsp_ld    = 1'b1;
                        rsp_err_d = 1'b1;
                    end else if (usr_rd_vld) begin
`ifdef ETH_CFG_SEQ_WR_VERIFY_EN
                        if (vfy_q && usr_rd_data == wr_data_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_RSP;
                            rsp_ld     = 1'b1;
                            rsp_err_d  = vfy_q;
                            rsp_data_d = usr_rd_data;
                        end
`else
                        state_d    = S_RSP;
                        rsp_ld     = 1'b1;
                        rsp_data_d = usr_rd_data;
`endif
                    end else if (tmr_last) begin
                        state_d   = S_RSP;
                        rsp_ld    = 1'b1;
                        rsp_err_d = 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        state_d = eth_init_done ? S_IDLE : S_WAIT_INIT;
                    end
                end
                default: state_d = S_DISABLED;
            endcase
        end
    end

    // Datapath: latched command fields, pacing counters, response and error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            eth_en_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            gap_cnt    <= '0;
            tmr        <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            eth_en_q <= seq_en;
            if (pop && !head_rd) begin
                wr_addr_q <= head_addr;
                wr_data_q <= head_data;
            end
            gap_cnt <= (state_q == S_GAP) ? gap_cnt + GW'(1) : '0;
            tmr     <= (state_q == S_RD_WAIT) ? tmr + TW'(1) : '0;
            if (rsp_ld) begin
                rsp_err_q  <= rsp_err_d;
                rsp_data_q <= rsp_data_d;
            end
            if (rsp_ld && rsp_err_d && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // Read address holds between strobes; readback reuses the write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
        end else if (pop && head_rd) begin
            rd_addr_q <= head_addr;
`ifdef ETH_CFG_SEQ_WR_VERIFY_EN
        end else if (vfy_start) begin
            rd_addr_q <= wr_addr_q;
`endif
        end
    end

`ifdef ETH_CFG_SEQ_WR_VERIFY_EN
    // Marks the outstanding read as an automatic readback of the last write.
    always_ff @(posedge clk) begin
        if (rst) begin
            vfy_q <= 1'b0;
        end else if (pop) begin
            vfy_q <= 1'b0;
        end else if (vfy_start) begin
            vfy_q <= 1'b1;
        end
    end
`endif

    assign usr_wr_en   = (state_q == S_WR) && eth_init_done && seq_en;
    assign usr_rd_en   = (state_q == S_RD) && eth_init_done && seq_en;
    assign usr_wr_addr = wr_addr_q;
    assign usr_wr_data = wr_data_q;
    assign usr_rd_addr = rd_addr_q;
    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_rdata   = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign eth_en      = eth_en_q;
    assign err_cnt     = err_cnt_q;
    assign fifo_level  = level;
    assign busy        = (state_q inside {S_WR, S_GAP, S_RD, S_RD_WAIT, S_RSP})
                         || !fifo_empty;

endmodule

// File: tb/tb_eth_cfg_seq.sv
// tb_eth_cfg_seq: directed stimulus for eth_cfg_seq with strobe and response scoreboards.
// Expected strobes carry their exact cycle; responses are compared on handshake.
module tb_eth_cfg_seq;

    logic        clk = 1'b0;
    logic        rst, seq_en;
    logic        cmd_valid, cmd_ready, cmd_rd;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        eth_en, eth_rst_done, eth_init_done;
    logic        usr_wr_en, usr_rd_en, usr_rd_vld;
    logic [31:0] usr_wr_addr, usr_wr_data, usr_rd_addr, usr_rd_data;
    logic        busy;
    logic [3:0]  fifo_level;
    logic [15:0] err_cnt;

    eth_cfg_seq dut (
        .clk(clk), .rst(rst), .seq_en(seq_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .eth_en(eth_en), .eth_rst_done(eth_rst_done),
        .eth_init_done(eth_init_done),
        .usr_wr_en(usr_wr_en), .usr_wr_addr(usr_wr_addr),
        .usr_wr_data(usr_wr_data), .usr_rd_en(usr_rd_en),
        .usr_rd_addr(usr_rd_addr), .usr_rd_vld(usr_rd_vld),
        .usr_rd_data(usr_rd_data), .busy(busy),
        .fifo_level(fifo_level), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        int          at;
    } stb_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    stb_t sq[$];
    rsp_t rq[$];
    stb_t se;
    rsp_t re;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe and every accepted response must match the queue head.
    always @(negedge clk) begin
        if (usr_wr_en || usr_rd_en) begin
            if (sq.size() == 0) begin
                chk("unexpected_strobe", {usr_rd_en, usr_wr_en}, 0);
            end else begin
                se = sq.pop_front();
                chk("stb_kind", {usr_rd_en, usr_wr_en}, {se.rd, !se.rd});
                chk("stb_cycle", cyc, se.at);
                if (se.rd) begin
                    chk("stb_rd_addr", usr_rd_addr, se.addr);
                end else begin
                    chk("stb_wr_addr", usr_wr_addr, se.addr);
                    chk("stb_wr_data", usr_wr_data, se.data);
                end
            end
        end
        if (rsp_valid && rsp_ready) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", {rsp_err, rsp_rdata}, 0);
            end else begin
                re = rq.pop_front();
                chk("rsp_data", rsp_rdata, re.data);
                chk("rsp_err", rsp_err, re.err);
            end
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) nxt();
    endtask

    task automatic push(input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output int hs);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("push_timeout", 0, 1);
        hs = cyc;
        nxt();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
        nxt();
    endtask

    int hs, h0, c0, r, d, n, i0;

    initial begin
        rst = 1'b1; seq_en = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        eth_rst_done = 1'b0; eth_init_done = 1'b0;
        usr_rd_vld = 1'b0; usr_rd_data = '0;
        repeat (3) nxt();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_eth_en", eth_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_strobes", {usr_wr_en, usr_rd_en}, 0);
        chk("rst_usr_bus", {usr_wr_addr, usr_wr_data}, 0);
        nxt();
        rst = 1'b0;

        // Bring-up: eth_en follows seq_en by one cycle; no strobe before init.
        nxt();
        seq_en = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("eth_en_delay0", eth_en, 0);
        @(negedge clk);
        chk("eth_en_delay1", eth_en, 1);
        nxt();
        push(1'b0, 32'h504, 32'h4000_0000, hs);
        goto(c0 + 20);
        eth_rst_done = 1'b1;
        eth_init_done = 1'b1;
        sq.push_back('{1'b0, 32'h504, 32'h4000_0000, c0 + 22});
        wait_idle(200);

        // Burst: one write in flight, eight more fill the FIFO.
        push(1'b0, 32'h1000, 32'hA0, hs);
        h0 = hs;
        sq.push_back('{1'b0, 32'h1000, 32'hA0, h0 + 2});
        for (int k = 1; k <= 8; k++) begin
            push(1'b0, 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k), hs);
            chk("burst_hs", hs, h0 + k);
            sq.push_back('{1'b0, 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k),
                           h0 + 2 + 18 * k});
        end
        cmd_valid = 1'b1;
        cmd_rd = 1'b0;
        cmd_addr = 32'hBAD;
        cmd_wdata = 32'hBAD;
        @(negedge clk);
        chk("full_level", fifo_level, 8);
        chk("full_cmd_ready", cmd_ready, 0);
        nxt();
        cmd_valid = 1'b0;
        wait_idle(400);

        // Read with data 5 cycles after the strobe; response held while not ready.
        rsp_ready = 1'b0;
        push(1'b1, 32'h4F8, 32'h0, hs);
        r = hs + 2;
        sq.push_back('{1'b1, 32'h4F8, 32'h0, r});
        rq.push_back('{32'h1234_5678, 1'b0});
        goto(r + 5);
        usr_rd_vld = 1'b1;
        usr_rd_data = 32'h1234_5678;
        nxt();
        usr_rd_vld = 1'b0;
        usr_rd_data = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rsp_hold", {rsp_valid, rsp_err, rsp_rdata},
                {1'b1, 1'b0, 32'h1234_5678});
        end
        nxt();
        rsp_ready = 1'b1;
        nxt();
        @(negedge clk);
        chk("rsp_clear", rsp_valid, 0);
        wait_idle(50);

        // Read timeout; a late rd_vld must be ignored.
        push(1'b1, 32'h100, 32'h0, hs);
        r = hs + 2;
        sq.push_back('{1'b1, 32'h100, 32'h0, r});
        rq.push_back('{32'h0, 1'b1});
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 1100) begin
            @(negedge clk);
            n++;
        end
        d = cyc - r;
        checks++;
        if (!rsp_valid || d < 1024 || d > 1025) begin
            errors++;
            $display("FAIL timeout_lat act=%0d exp=1024..1025 valid=%0b",
                     d, rsp_valid);
        end
        nxt();
        @(negedge clk);
        chk("timeout_err_cnt", err_cnt, 1);
        nxt();
        usr_rd_vld = 1'b1;
        usr_rd_data = 32'hDEAD_BEEF;
        nxt();
        usr_rd_vld = 1'b0;
        usr_rd_data = '0;
        repeat (3) nxt();
        @(negedge clk);
        chk("late_vld_rsp", rsp_valid, 0);
        chk("late_vld_err_cnt", err_cnt, 1);
        nxt();

        // Abort a pending read with three commands queued behind it.
        push(1'b1, 32'h200, 32'h0, hs);
        r = hs + 2;
        sq.push_back('{1'b1, 32'h200, 32'h0, r});
        rq.push_back('{32'h0, 1'b1});
        push(1'b0, 32'h210, 32'h11, hs);
        push(1'b0, 32'h214, 32'h22, hs);
        push(1'b0, 32'h218, 32'h33, hs);
        goto(r + 6);
        eth_init_done = 1'b0;
        goto(r + 12);
        @(negedge clk);
        chk("abort_level", fifo_level, 3);
        chk("abort_err_cnt", err_cnt, 2);
        chk("abort_rsp_done", rsp_valid, 0);
        nxt();
        eth_init_done = 1'b1;
        i0 = cyc;
        sq.push_back('{1'b0, 32'h210, 32'h11, i0 + 2});
        sq.push_back('{1'b0, 32'h214, 32'h22, i0 + 20});
        sq.push_back('{1'b0, 32'h218, 32'h33, i0 + 38});
        wait_idle(200);

        // seq_en drop with five queued: flush, eth_en low, no more strobes.
        push(1'b0, 32'h300, 32'h55, hs);
        sq.push_back('{1'b0, 32'h300, 32'h55, hs + 2});
        for (int k = 1; k <= 5; k++) begin
            push(1'b0, 32'h300 + 32'(4 * k), 32'h55 + 32'(k), hs);
        end
        @(negedge clk);
        chk("pre_drop_level", fifo_level, 5);
        nxt();
        seq_en = 1'b0;
        @(negedge clk);
        chk("drop_cmd_ready", cmd_ready, 0);
        nxt();
        @(negedge clk);
        chk("drop_level", fifo_level, 0);
        chk("drop_eth_en", eth_en, 0);
        chk("drop_busy", busy, 0);
        repeat (60) nxt();

        chk("stb_queue_left", sq.size(), 0);
        chk("rsp_queue_left", rq.size(), 0);
        chk("final_err_cnt", err_cnt, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
